// File: rtl/bitmanip_bextdep_unit_pkg.sv
// Shared types for the iterative BEXT/BDEP unit: functional-unit opcodes, scoreboard tag
// width and the unit's FSM state encoding.
package bitmanip_bextdep_unit_pkg;

  localparam int TRANS_ID_BITS = 3;

  typedef enum logic [3:0] {
    ADD,
    SUB,
    MUL,
    MULH,
    DIV,
    REM,
    BEXT,
    BDEP
  } fu_op;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } bextdep_state_t;

  function automatic logic is_bextdep(input fu_op op);
    return (op == BEXT) || (op == BDEP);
  endfunction

endpackage

// File: rtl/bitmanip_bextdep_unit_chunk.sv
// Combinational bextdep chunk step: gathers (BEXT) or scatters (BDEP) one mask chunk
// into the accumulator, starting at packed pointer k, and reports the chunk popcount.
module bitmanip_bextdep_unit_chunk
  import bitmanip_bextdep_unit_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 8,
  parameter int IW             = $clog2(XLEN),
  parameter int KW             = IW + 1
) (
  input  fu_op                      op_i,
  input  logic [XLEN-1:0]           a_i,
  input  logic [BITS_PER_CYCLE-1:0] mask_chunk_i,
  input  logic [IW-1:0]             base_i,
  input  logic [KW-1:0]             k_i,
  input  logic [XLEN-1:0]           acc_i,
  output logic [XLEN-1:0]           acc_o,
  output logic [KW-1:0]             popcnt_o
);

  logic [KW-1:0] pre;
  logic [IW-1:0] idx;

  // pre is the per-bit prefix count: k plus the set mask bits below bit j of this chunk.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch;
    // blocking assignments here are intentional so pre accumulates bit by bit.
    acc_o = acc_i;
    pre   = k_i;
    idx   = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      idx = base_i + IW'(j);
      if (mask_chunk_i[j]) begin
        if (pre < KW'(XLEN)) begin
          if (op_i == BEXT) acc_o[pre[IW-1:0]] = a_i[idx];
          else              acc_o[idx]         = a_i[pre[IW-1:0]];
        end
        pre = pre + KW'(1);
      end
    end
    popcnt_o = pre - k_i;
  end

endmodule

// File: rtl/bitmanip_bextdep_unit.sv
// Iterative BEXT/BDEP producer: walks the mask one chunk per BUSY cycle and stops early
// once no set mask bits remain; the result is presented for one DONE cycle.
module bitmanip_bextdep_unit
  import bitmanip_bextdep_unit_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  fu_op                     operator_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o
);

  localparam int IW = $clog2(XLEN);
  localparam int KW = IW + 1;

  bextdep_state_t           state_q, state_d;
  fu_op                     op_q, op_d;
  logic [TRANS_ID_BITS-1:0] tid_q, tid_d;
  logic [XLEN-1:0]          a_q, a_d;
  logic [XLEN-1:0]          mask_q, mask_d;
  logic [XLEN-1:0]          acc_q, acc_d;
  logic [IW-1:0]            c_q, c_d;
  logic [KW-1:0]            k_q, k_d;

  logic                     accept;
  logic                     last_chunk;
  logic [IW-1:0]            base;
  logic [XLEN-1:0]          chunk_acc;
  logic [KW-1:0]            chunk_pop;

  assign ready_o    = ((state_q == IDLE) || (state_q == DONE)) && !flush_i;
  assign accept     = valid_i && ready_o && is_bextdep(operator_i);
  assign valid_o    = (state_q == DONE) && !flush_i;
  assign result_o   = acc_q;
  assign trans_id_o = tid_q;

  // mask_q is shifted down as chunks retire, so its low bits are always the current chunk.
  assign last_chunk = (mask_q >> BITS_PER_CYCLE) == '0;
  assign base       = IW'(c_q * BITS_PER_CYCLE);

  bitmanip_bextdep_unit_chunk #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_chunk (
    .op_i         (op_q),
    .a_i          (a_q),
    .mask_chunk_i (mask_q[BITS_PER_CYCLE-1:0]),
    .base_i       (base),
    .k_i          (k_q),
    .acc_i        (acc_q),
    .acc_o        (chunk_acc),
    .popcnt_o     (chunk_pop)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tid_d   = tid_q;
    a_d     = a_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    c_d     = c_q;
    k_d     = k_q;
    case (state_q)
      BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d  = chunk_acc;
          k_d    = k_q + chunk_pop;
          c_d    = c_q + IW'(1);
          mask_d = mask_q >> BITS_PER_CYCLE;
          if (last_chunk) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Accept is only possible from IDLE/DONE and overrides their default transition.
    if (accept) begin
      state_d = BUSY;
      op_d    = operator_i;
      tid_d   = trans_id_i;
      a_d     = operand_a_i;
      mask_d  = operand_b_i;
      acc_d   = '0;
      c_d     = '0;
      k_d     = '0;
    end
  end

  // NOTE: reset is synchronous (sampled on the clock edge) and all state uses non-blocking
  // assignments so every register updates from the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= ADD;
      tid_q   <= '0;
      a_q     <= '0;
      mask_q  <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tid_q   <= tid_d;
      a_q     <= a_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_bitmanip_bextdep_unit.sv
// Directed bench for bitmanip_bextdep_unit: table of BEXT/BDEP vectors with hand-computed
// results and latencies, then back-to-back, flush and reset sequences.
module tb_bitmanip_bextdep_unit;
  import bitmanip_bextdep_unit_pkg::*;

  localparam int XLEN = 64;
  localparam int TID  = TRANS_ID_BITS;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            valid_i;
  fu_op            operator_i;
  logic [TID-1:0]  trans_id_i;
  logic [XLEN-1:0] operand_a_i;
  logic [XLEN-1:0] operand_b_i;
  logic            ready_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic [TID-1:0]  trans_id_o;

  bitmanip_bextdep_unit #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .operator_i  (operator_i),
    .trans_id_i  (trans_id_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .result_o    (result_o),
    .trans_id_o  (trans_id_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    fu_op            op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] exp;
    int              lat;
  } vec_t;

  vec_t vecs[12];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drives one request at a negedge; returns at the negedge of cycle T+1.
  task automatic start_op(input fu_op op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] m,
                          input logic [TID-1:0] tid);
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = m;
    trans_id_i  = tid;
    valid_i     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  // Counts cycles after accept until valid_o; cnt=1 is cycle T+1. Bounded at 30.
  task automatic wait_valid(output int cnt, output bit ready_bad);
    cnt       = 1;
    ready_bad = 1'b0;
    while (!valid_o && cnt < 30) begin
      if (ready_o) ready_bad = 1'b1;
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic watch_none(input int n, output bit seen);
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (valid_o) seen = 1'b1;
    end
  endtask

  task automatic run_op(input string name, input fu_op op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] m, input logic [TID-1:0] tid,
                        input logic [XLEN-1:0] exp, input int lat);
    int cnt;
    bit rb;
    start_op(op, a, m, tid);
    wait_valid(cnt, rb);
    check({name, " latency"}, 64'(cnt), 64'(lat));
    check({name, " result"}, result_o, exp);
    check({name, " trans_id"}, 64'(trans_id_o), 64'(tid));
    check({name, " ready low in BUSY"}, 64'(rb), 64'(0));
    check({name, " ready in DONE"}, 64'(ready_o), 64'(1));
    @(negedge clk);
    check({name, " single pulse"}, 64'(valid_o), 64'(0));
  endtask

  initial begin
    int cnt;
    bit rb;
    bit seen;

    vecs[0]  = '{BEXT, 64'hABCD, 64'hFF00, 64'hAB, 3};
    vecs[1]  = '{BDEP, 64'hAB, 64'hFF00, 64'hAB00, 3};
    vecs[2]  = '{BDEP, 64'hF, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 9};
    vecs[3]  = '{BEXT, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h0123_4567_89AB_CDEF, 9};
    vecs[4]  = '{BEXT, 64'hDEAD_BEEF, 64'h0, 64'h0, 2};
    vecs[5]  = '{BDEP, 64'hDEAD_BEEF, 64'h0, 64'h0, 2};
    vecs[6]  = '{BEXT, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h1, 9};
    vecs[7]  = '{BDEP, 64'h1, 64'h0000_0000_0100_0000, 64'h0000_0000_0100_0000, 5};
    vecs[8]  = '{BEXT, 64'h5555, 64'h00FF, 64'h55, 2};
    vecs[9]  = '{BDEP, 64'h5, 64'h0000_0F00_0000_0000, 64'h0000_0500_0000_0000, 7};
    vecs[10] = '{BEXT, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 64'h2, 9};
    vecs[11] = '{BEXT, 64'hF0F0, 64'hAAAA, 64'hCC, 3};

    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    valid_i     = 1'b0;
    operator_i  = ADD;
    trans_id_i  = '0;
    operand_a_i = '0;
    operand_b_i = '0;
    repeat (2) @(negedge clk);
    check("reset ready", 64'(ready_o), 64'(1));
    check("reset valid", 64'(valid_o), 64'(0));
    check("reset result", result_o, 64'h0);
    check("reset trans_id", 64'(trans_id_o), 64'(0));
    rst_ni = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].mask, TID'(i),
             vecs[i].exp, vecs[i].lat);

    // Non-bext/bdep operator must be ignored.
    operator_i  = MUL;
    operand_b_i = 64'hFF;
    trans_id_i  = 3'd6;
    valid_i     = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    check("foreign op stays ready", 64'(ready_o), 64'(1));
    watch_none(12, seen);
    check("foreign op no valid", 64'(seen), 64'(0));

    // Back-to-back: second op issued in the DONE cycle of the first.
    start_op(BEXT, 64'hABCD, 64'hFF00, 3'd1);
    wait_valid(cnt, rb);
    check("b2b A latency", 64'(cnt), 64'(3));
    check("b2b A result", result_o, 64'hAB);
    check("b2b A trans_id", 64'(trans_id_o), 64'(1));
    check("b2b A ready in DONE", 64'(ready_o), 64'(1));
    start_op(BDEP, 64'hAB, 64'hFF00, 3'd2);
    check("b2b A single pulse", 64'(valid_o), 64'(0));
    check("b2b B busy not ready", 64'(ready_o), 64'(0));
    wait_valid(cnt, rb);
    check("b2b B latency", 64'(cnt), 64'(3));
    check("b2b B result", result_o, 64'hAB00);
    check("b2b B trans_id", 64'(trans_id_o), 64'(2));
    check("b2b B ready low in BUSY", 64'(rb), 64'(0));
    @(negedge clk);
    check("b2b B single pulse", 64'(valid_o), 64'(0));

    // Flush at T+2 of a T+9 op.
    start_op(BEXT, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3);
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("flush ready low", 64'(ready_o), 64'(0));
    @(negedge clk);
    flush_i = 1'b0;
    watch_none(15, seen);
    check("flush no valid", 64'(seen), 64'(0));
    check("flush back to idle", 64'(ready_o), 64'(1));

    // Flush and issue in the same cycle: not accepted.
    operator_i  = BDEP;
    operand_a_i = 64'hF;
    operand_b_i = 64'hF;
    trans_id_i  = 3'd5;
    valid_i     = 1'b1;
    flush_i     = 1'b1;
    #1;
    check("flush+issue ready low", 64'(ready_o), 64'(0));
    @(negedge clk);
    valid_i = 1'b0;
    flush_i = 1'b0;
    watch_none(12, seen);
    check("flush+issue no valid", 64'(seen), 64'(0));
    check("flush+issue tag kept", 64'(trans_id_o), 64'(3));

    // Flush in the DONE cycle suppresses valid_o.
    start_op(BEXT, 64'h5, 64'h0, 3'd6);
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("done flush valid", 64'(valid_o), 64'(0));
    check("done flush ready", 64'(ready_o), 64'(0));
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("done flush idle", 64'(ready_o), 64'(1));
    watch_none(5, seen);
    check("done flush no valid", 64'(seen), 64'(0));

    // Reset for one cycle mid-BUSY.
    start_op(BDEP, 64'hF, 64'h8000_0000_0000_0001, 3'd7);
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    check("mid reset ready", 64'(ready_o), 64'(1));
    check("mid reset valid", 64'(valid_o), 64'(0));
    check("mid reset result", result_o, 64'h0);
    check("mid reset trans_id", 64'(trans_id_o), 64'(0));
    watch_none(12, seen);
    check("mid reset no valid", 64'(seen), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
